flow_zigzag: RTL and testbench

//  Zigzag reorder stage placed directly downstream of flow_divider in the JPEG encode path.

---
 rtl/flow_zigzag.sv | 166 ++++++++++++++++
 tb/tb_flow_zigzag.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/flow_zigzag.sv
// rtl/flow_zigzag.sv - JPEG zigzag reorder stage with ping-pong block banks
module flow_zigzag #(
    parameter int N = 2,
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic [N-1:0][W-1:0] in_data,
    input  logic                in_sob,
    input  logic                in_eob,
    input  logic                in_sof,
    output logic                out_valid,
    output logic [N-1:0][W-1:0] out_data,
    output logic                out_sob,
    output logic                out_eob,
    output logic                out_sof,
    output logic                out_err
);
    localparam int BEATS = 64 / N;
    localparam int BW = $clog2(BEATS);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    localparam int ZZ [64] = '{
        0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    logic [W-1:0]        mem_q [2][64];
    logic [BW-1:0]       wcnt_q, wcnt_d, rcnt_q, rcnt_d, widx;
    logic                wb_q, wb_d, rbank_q, rbank_d, rd_act_q, rd_act_d;
    logic [1:0]          full_q, full_d, bsof_q, bsof_d;
    logic                cur_sof_q, cur_sof_d, drop_q, drop_d, stray_q, stray_d;
    logic                err_d, wr_en, commit, rel;
    logic                out_valid_d, out_sob_d, out_eob_d, out_sof_d;
    logic [N-1:0][W-1:0] out_data_d;

    always_comb begin
        wcnt_d    = wcnt_q;
        wb_d      = wb_q;
        bsof_d    = bsof_q;
        cur_sof_d = cur_sof_q;
        drop_d    = drop_q;
        stray_d   = stray_q;
        err_d     = 1'b0;
        wr_en     = 1'b0;
        commit    = 1'b0;
        widx      = in_sob ? '0 : wcnt_q;
        if (in_valid) begin
            if (in_sob) cur_sof_d = in_sof;
            if (drop_q && !in_sob) begin
                // Stray beats of a dropped block report once, then stay silent
                if (!stray_q) begin
                    err_d   = 1'b1;
                    stray_d = 1'b1;
                end
            end else begin
                drop_d  = 1'b0;
                stray_d = 1'b0;
                if (in_eob && widx == LAST) begin
                    wcnt_d = '0;
                    if (&full_q) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en          = 1'b1;
                        commit         = 1'b1;
                        wb_d           = ~wb_q;
                        bsof_d[wb_q]   = in_sob ? in_sof : cur_sof_q;
                    end
                end else if (in_eob || widx == LAST) begin
                    err_d  = 1'b1;
                    drop_d = 1'b1;
                    wcnt_d = '0;
                end else begin
                    wr_en  = 1'b1;
                    wcnt_d = widx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_act_d    = rd_act_q;
        rbank_d     = rbank_q;
        rcnt_d      = rcnt_q;
        rel         = 1'b0;
        out_valid_d = 1'b0;
        out_sob_d   = 1'b0;
        out_eob_d   = 1'b0;
        out_sof_d   = 1'b0;
        out_data_d  = '0;
        if (rd_act_q) begin
            out_valid_d = 1'b1;
            out_sob_d   = (rcnt_q == '0);
            out_eob_d   = (rcnt_q == LAST);
            out_sof_d   = (rcnt_q == '0) && bsof_q[rbank_q];
            for (int i = 0; i < N; i++)
                out_data_d[i] = mem_q[rbank_q][6'(ZZ[6'(int'(rcnt_q) * N + i)])];
            if (rcnt_q == LAST) begin
                rel = 1'b1;
                if (full_q[~rbank_q]) begin
                    rbank_d = ~rbank_q;
                    rcnt_d  = '0;
                end else begin
                    rd_act_d = 1'b0;
                end
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end else if (|full_q) begin
            // With both banks full, the write pointer names the older block
            rd_act_d = 1'b1;
            rcnt_d   = '0;
            rbank_d  = (&full_q) ? wb_q : full_q[1];
        end
        full_d = full_q;
        if (rel) full_d[rbank_q] = 1'b0;
        if (commit) full_d[wb_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (en && wr_en) begin
            for (int i = 0; i < N; i++)
                mem_q[wb_q][6'(int'(widx) * N + i)] <= in_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q    <= '0;
            wb_q      <= 1'b0;
            full_q    <= '0;
            bsof_q    <= '0;
            cur_sof_q <= 1'b0;
            drop_q    <= 1'b0;
            stray_q   <= 1'b0;
            rd_act_q  <= 1'b0;
            rbank_q   <= 1'b0;
            rcnt_q    <= '0;
            out_valid <= 1'b0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
            out_err   <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            wcnt_q    <= wcnt_d;
            wb_q      <= wb_d;
            full_q    <= full_d;
            bsof_q    <= bsof_d;
            cur_sof_q <= cur_sof_d;
            drop_q    <= drop_d;
            stray_q   <= stray_d;
            rd_act_q  <= rd_act_d;
            rbank_q   <= rbank_d;
            rcnt_q    <= rcnt_d;
            out_valid <= out_valid_d;
            out_sob   <= out_sob_d;
            out_eob   <= out_eob_d;
            out_sof   <= out_sof_d;
            out_err   <= err_d;
            out_data  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_flow_zigzag.sv
// tb/tb_flow_zigzag.sv - directed self-checking bench for flow_zigzag
module tb_flow_zigzag;
    localparam int N = 2;
    localparam int W = 16;
    localparam int ZZ [64] = '{
        0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    logic clk = 1'b0, rst_n = 1'b1, en = 1'b1;
    logic in_valid = 1'b0, in_sob = 1'b0, in_eob = 1'b0, in_sof = 1'b0;
    logic [N-1:0][W-1:0] in_data = '0;
    logic out_valid, out_sob, out_eob, out_sof, out_err;
    logic [N-1:0][W-1:0] out_data;

    typedef struct {
        logic [31:0] d;
        logic        sob;
        logic        eob;
        logic        sof;
        int          cyc;
    } beat_t;

    beat_t       q[$];
    logic [15:0] blk [4][64];
    int          n_chk = 0, n_pass = 0, cyc = 0, eob_cyc = 0, errs = 0, frozen_bad = 0;
    int          en_mode = 0;
    logic        en_prev = 1'b1;
    logic [36:0] snap = '0;

    always #5 clk = ~clk;

    flow_zigzag #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_data(in_data), .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
        .out_valid(out_valid), .out_data(out_data), .out_sob(out_sob), .out_eob(out_eob),
        .out_sof(out_sof), .out_err(out_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        cyc++;
        en_prev = en;
        if (rst_n && en && in_valid && in_eob) eob_cyc = cyc;
    end

    always @(negedge clk) begin
        if (en_prev) begin
            if (out_valid) q.push_back('{out_data, out_sob, out_eob, out_sof, cyc});
            if (out_err) errs++;
        end else if ({out_valid, out_sob, out_eob, out_sof, out_err, out_data} !== snap) begin
            frozen_bad++;
        end
        snap = {out_valid, out_sob, out_eob, out_sof, out_err, out_data};
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            if (en_mode != 0) en = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic sob, input logic eob, input logic sof);
        logic took;
        in_valid = 1'b1; in_data = d; in_sob = sob; in_eob = eob; in_sof = sof;
        do begin
            if (en_mode != 0) en = ($urandom_range(0, 2) != 0);
            took = en;
            @(posedge clk); #1;
        end while (!took);
        in_valid = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_block(input int k, input logic sof, input int nb, input int eob_at, input int gapmax);
        for (int b = 0; b < nb; b++) begin
            if (gapmax > 0) idle($urandom_range(0, gapmax));
            beat({blk[k][(2*b+1)%64], blk[k][(2*b)%64]}, b == 0, b == eob_at, sof && (b == 0));
        end
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int t = 0;
        while (q.size() < n && t < budget) begin
            idle(1);
            t++;
        end
        idle(4);
        check({tag, "_count"}, q.size(), n);
    endtask

    task automatic check_block(input string tag, input int base, input int k, input logic sof);
        if (q.size() < base + 32) return;
        for (int b = 0; b < 32; b++) begin
            check($sformatf("%s_data%0d", tag, b), q[base+b].d,
                  {blk[k][ZZ[2*b+1]], blk[k][ZZ[2*b]]});
            check($sformatf("%s_flags%0d", tag, b), {q[base+b].sob, q[base+b].eob, q[base+b].sof},
                  {b == 0, b == 31, sof && (b == 0)});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            blk[0][i] = 16'(i);
            blk[1][i] = 16'(1000 + i);
            blk[2][i] = 16'($urandom);
            blk[3][i] = 16'(16'h8000 | (i * 7));
        end
        #2 rst_n = 1'b0;
        #10;
        check("rst_ctrl", {out_valid, out_sob, out_eob, out_sof, out_err}, 5'b0);
        check("rst_data", out_data, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // single block, raster ramp
        q.delete();
        send_block(0, 1'b1, 32, 31, 0);
        wait_out("t1", 32, 200);
        if (q.size() == 32) begin
            check("t1_latency", q[0].cyc - eob_cyc, 2);
            check("t1_beat0", q[0].d, {16'd1, 16'd0});
            check("t1_beat1", q[1].d, {16'd16, 16'd8});
            check("t1_beat31", q[31].d, {16'd63, 16'd62});
        end
        check_block("t1", 0, 0, 1'b1);

        // three blocks back to back
        q.delete();
        send_block(1, 1'b1, 32, 31, 0);
        send_block(2, 1'b0, 32, 31, 0);
        send_block(3, 1'b0, 32, 31, 0);
        wait_out("t2", 96, 300);
        if (q.size() == 96) check("t2_span", q[95].cyc - q[0].cyc, 95);
        check_block("t2a", 0, 1, 1'b1);
        check_block("t2b", 32, 2, 1'b0);
        check_block("t2c", 64, 3, 1'b0);

        // random gaps, random data
        for (int i = 0; i < 64; i++) blk[2][i] = 16'($urandom);
        q.delete();
        send_block(2, 1'b0, 32, 31, 5);
        wait_out("t3", 32, 300);
        if (q.size() == 32) check("t3_span", q[31].cyc - q[0].cyc, 31);
        check_block("t3", 0, 2, 1'b0);

        // short block then good block
        errs = 0;
        q.delete();
        send_block(0, 1'b0, 21, 20, 0);
        send_block(1, 1'b1, 32, 31, 0);
        wait_out("t4a", 32, 200);
        check("t4a_errs", errs, 1);
        check_block("t4a", 0, 1, 1'b1);

        // last beat without eob, then good block
        errs = 0;
        q.delete();
        send_block(0, 1'b0, 32, -1, 0);
        idle(2);
        send_block(3, 1'b0, 32, 31, 0);
        wait_out("t4b", 32, 200);
        check("t4b_errs", errs, 1);
        check_block("t4b", 0, 3, 1'b0);

        // random clock enable during input and output
        for (int i = 0; i < 64; i++) blk[2][i] = 16'($urandom);
        frozen_bad = 0;
        q.delete();
        en_mode = 1;
        send_block(2, 1'b1, 32, 31, 2);
        wait_out("t5", 32, 1000);
        en_mode = 0;
        en = 1'b1;
        check("t5_frozen", frozen_bad, 0);
        check_block("t5", 0, 2, 1'b1);

        // reset mid-block while reading the previous one
        q.delete();
        send_block(0, 1'b1, 32, 31, 0);
        send_block(1, 1'b0, 15, -1, 0);
        check("t6_reading", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {out_valid, out_sob, out_eob, out_sof, out_err}, 5'b0);
        check("t6_rst_data", out_data, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        errs = 0;
        for (int i = 0; i < 64; i++) blk[2][i] = 16'($urandom);
        send_block(2, 1'b1, 32, 31, 0);
        wait_out("t6", 32, 200);
        check("t6_errs", errs, 0);
        check_block("t6", 0, 2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
